// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter feeding four byte requesters into one uart_tx.
// Optional header frame (0xA0|grant) per transfer when UART_ARB_TAG_EN is defined.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   req_valid_i  per-requester byte-valid flags (bit i = requester i)
//   req_data_i   requester bytes, [8i+7:8i] for requester i
//   req_ready_o  one-cycle accept strobe for the granted requester
//   tx_start_o   one-cycle frame-start strobe to uart_tx
//   tx_data_o    byte presented to uart_tx
//   tx_done_i    uart_tx end-of-stop-bit pulse
//   grant_o      index of the requester owning the transmitter
//   busy_o       high whenever the arbiter is not idle
//
// Parameter GAP_CYCLES: idle cycles after each completed frame (0 = none).
// Macro UART_ARB_TAG_EN: adds HSTART/HWAIT to send a header byte before data.
module uart_tx_arbiter #(
  parameter int GAP_CYCLES = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req_valid_i,
  input  logic [31:0] req_data_i,
  output logic [3:0]  req_ready_o,
  output logic        tx_start_o,
  output logic [7:0]  tx_data_o,
  input  logic        tx_done_i,
  output logic [1:0]  grant_o,
  output logic        busy_o
);

  localparam int CW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int GL = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam logic [CW-1:0] GAP_LAST = CW'(GL);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_START,
    S_WAIT,
    S_GAP
`ifdef UART_ARB_TAG_EN
    ,
    S_HSTART,
    S_HWAIT
`endif
  } state_t;

  state_t        state_q;
  logic [3:0]    ready_q;
  logic          start_q;
  logic [7:0]    txd_q;
  logic [1:0]    grant_q;
  logic [1:0]    last_q;
  logic [CW-1:0] gap_q;
`ifdef UART_ARB_TAG_EN
  logic [7:0]    data_q;
`endif

  logic          hit_d;
  logic [1:0]    pick_d;
  logic [1:0]    cand;
  logic [7:0]    byte_d;

  // Search upward from last_q+1; iterate farthest-first so the
  // nearest candidate overwrites and wins.
  always_comb begin
    hit_d  = 1'b0;
    pick_d = last_q;
    cand   = '0;
    for (int k = 4; k >= 1; k--) begin
      cand = last_q + 2'(k);
      if (req_valid_i[cand]) begin
        hit_d  = 1'b1;
        pick_d = cand;
      end
    end
  end

  assign byte_d = req_data_i[{grant_q, 3'b000} +: 8];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ready_q <= '0;
      start_q <= 1'b0;
      txd_q   <= '0;
      grant_q <= '0;
      last_q  <= 2'd3;
      gap_q   <= '0;
`ifdef UART_ARB_TAG_EN
      data_q  <= '0;
`endif
    end else begin
      ready_q <= '0;
      start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (hit_d) begin
            grant_q <= pick_d;
            last_q  <= pick_d;
            ready_q <= 4'b0001 << pick_d;
            state_q <= S_GRANT;
          end
        end
        S_GRANT: begin
          // A requester that dropped valid loses its turn;
          // last_q already advanced so rotation continues.
          if (req_valid_i[grant_q]) begin
            start_q <= 1'b1;
`ifdef UART_ARB_TAG_EN
            data_q  <= byte_d;
            txd_q   <= {6'b101000, grant_q};
            state_q <= S_HSTART;
`else
            txd_q   <= byte_d;
            state_q <= S_START;
`endif
          end else begin
            state_q <= S_IDLE;
          end
        end
`ifdef UART_ARB_TAG_EN
        S_HSTART: state_q <= S_HWAIT;
        S_HWAIT: begin
          if (tx_done_i) begin
            txd_q   <= data_q;
            start_q <= 1'b1;
            state_q <= S_START;
          end
        end
`endif
        S_START: state_q <= S_WAIT;
        S_WAIT: begin
          if (tx_done_i) begin
            gap_q <= '0;
            if (GAP_CYCLES == 0) begin
              state_q <= S_IDLE;
            end else begin
              state_q <= S_GAP;
            end
          end
        end
        S_GAP: begin
          if (gap_q == GAP_LAST) begin
            gap_q   <= '0;
            state_q <= S_IDLE;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready_o = ready_q;
  assign tx_start_o  = start_q;
  assign tx_data_o   = txd_q;
  assign grant_o     = grant_q;
  assign busy_o      = (state_q != S_IDLE);

endmodule
